wb_port_arbiter: RTL
====================

Name: wb_port_arbiter

Overview:
- Owns the single register-file write port at the end of the 3-stage pipeline.
- Shares that port between two sources:
  - the in-order writeback result (wbdataMW / rd from the MW stage);
  - a long-latency requester (UART/peripheral load, multi-cycle unit) that returns results out of band.
- Buffers late results in a small FIFO and drains them into idle write slots.
- Forces a pipeline stall when a late result starves.
- Keeps a pending-destination scoreboard so decode never reads, or overwrites, a register with an outstanding late write.

Parameters:
- BUS_WIDTH, 32, data width (value from the shared header).
- RADDR_W, 5, register address width.
- FIFO_DEPTH, 2, late-result buffer entries (power of 2, at least 2).
- MAX_WAIT, 4, cycles a buffered head entry may wait before a stall is forced (at least 1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wb_en_MW  in  1  pipeline writeback request this cycle
- rd_MW  in  RADDR_W  pipeline destination
- wbdata_MW  in  BUS_WIDTH  pipeline writeback data
- lt_issue  in  1  decode issues a late-result instruction this cycle
- lt_issue_rd  in  RADDR_W  its destination
- lt_valid  in  1  late result offered
- lt_rd  in  RADDR_W  late result destination
- lt_data  in  BUS_WIDTH  late result data
- lt_ready  out  1  FIFO can accept; transfer occurs when lt_valid && lt_ready
- rs1_D, rs2_D, rd_D  in  RADDR_W  decode operand/destination addresses
- hazard_D  out  1  decode must stall (pending match)
- stall_MW  out  1  pipeline must hold MW this cycle (port taken by late entry)
- rf_we  out  1  register-file write enable
- rf_waddr  out  RADDR_W  register-file write address
- rf_wdata  out  BUS_WIDTH  register-file write data

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty, count=0, age=0, scoreboard all zero, state=IDLE;
  - outputs rf_we=0, rf_waddr=0, rf_wdata=0, stall_MW=0, hazard_D=0, lt_ready=1 once rst_n releases.
  - Reset mid-operation discards buffered entries and pending bits.
- Write port is combinational from current state and inputs (zero added latency); the write commits at the clk edge.
- Writes to x0 are never issued: rf_we is forced to 0 when the address is 0. x0 requests consume no slot, and x0 late results are accepted and dropped.
- FSM:
  - IDLE: FIFO empty. Port follows the pipeline (rf_we = wb_en_MW && rd_MW != 0). Goes to DRAIN on an accepted late result.
  - DRAIN: FIFO non-empty.
    - If wb_en_MW=1, the pipeline wins, the head waits and age increments.
    - Otherwise the head is written, popped, and age resets to 0.
    - Goes to IDLE when the last entry pops with no concurrent push.
    - Goes to FORCE when age reaches MAX_WAIT-1 and the head is still blocked.
  - FORCE: stall_MW=1 for exactly one cycle and the head is written regardless of wb_en_MW (the pipeline holds and retries next cycle). Age resets. Goes to DRAIN if entries remain, else IDLE.
- FIFO:
  - lt_ready = (count < FIFO_DEPTH).
  - Simultaneous push and pop when full is not allowed (ready is already low).
  - Push and pop in the same cycle when partially full keeps count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Scoreboard (2^RADDR_W bits):
  - lt_issue sets bit[lt_issue_rd] (never for x0).
  - A late write to rf clears bit[waddr].
  - Set and clear of the same index in the same cycle resolves as set (the new issue wins).
- hazard_D = pending[rs1_D] | pending[rs2_D] | pending[rd_D], each term only for a nonzero address. This covers RAW and WAW against late results. Pending state is registered, so the hazard drops the cycle after the commit.
- Illegal input combinations, each caught by an assertion:
  - lt_valid for a non-pending rd;
  - wb_en_MW to a pending rd.

Decomposition:
- Shared package: RADDR_W, FIFO_DEPTH, MAX_WAIT defaults, and the arbiter state enum (IDLE, DRAIN, FORCE). BUS_WIDTH comes from the existing header.
- One sub-module: wb_late_fifo (synchronous FIFO, valid/ready push, pop-on-grant, count output).

Test Plan:
- Reset, then wb_en_MW=1, rd_MW=5, data=0x12345678 -> same cycle rf_we=1, waddr=5, wdata=0x12345678, stall_MW=0.
- lt_issue rd=7, then lt_valid rd=7 data=0xA5A5A5A5 on an idle pipeline -> hazard_D=1 for rs1_D=7 until the commit; write lands 1 cycle after acceptance; hazard_D=0 the cycle after that.
- Two late results accepted back-to-back, with wb_en_MW=1 continuously -> lt_ready=0 after 2 pushes; after MAX_WAIT=4 blocked cycles stall_MW=1 for one cycle with the head written; the second entry is forced 4 cycles later.
- Push and pop in the same cycle at count=1 -> count stays 1, FIFO order preserved (rd 3 then rd 4 written in order).
- lt_valid rd=0, and wb_en_MW with rd_MW=0 -> rf_we never asserts; FIFO count returns to 0.
- Assert rst_n=0 while FIFO holds 2 entries and stall_MW=1 -> all outputs zero immediately; scoreboard clear after release (hazard_D=0 for all rs).

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants and arbiter state type for the register-file write-port arbiter.
// BUS_WIDTH mirrors the datapath width used across the core.
package wb_port_arbiter_pkg;

  localparam int unsigned BUS_WIDTH  = 32;
  localparam int unsigned RADDR_W    = 5;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned MAX_WAIT   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FORCE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of pipeline, late-result, decode and register-file signals around the
// write-port arbiter. The slave modport is the arbiter side.
interface wb_port_arbiter_if #(
  parameter int unsigned BUS_WIDTH = wb_port_arbiter_pkg::BUS_WIDTH,
  parameter int unsigned RADDR_W   = wb_port_arbiter_pkg::RADDR_W
);

  logic                 wb_en_MW;
  logic [RADDR_W-1:0]   rd_MW;
  logic [BUS_WIDTH-1:0] wbdata_MW;
  logic                 lt_issue;
  logic [RADDR_W-1:0]   lt_issue_rd;
  logic                 lt_valid;
  logic [RADDR_W-1:0]   lt_rd;
  logic [BUS_WIDTH-1:0] lt_data;
  logic                 lt_ready;
  logic [RADDR_W-1:0]   rs1_D;
  logic [RADDR_W-1:0]   rs2_D;
  logic [RADDR_W-1:0]   rd_D;
  logic                 hazard_D;
  logic                 stall_MW;
  logic                 rf_we;
  logic [RADDR_W-1:0]   rf_waddr;
  logic [BUS_WIDTH-1:0] rf_wdata;

  modport slave (
    input  wb_en_MW, rd_MW, wbdata_MW,
    input  lt_issue, lt_issue_rd,
    input  lt_valid, lt_rd, lt_data,
    output lt_ready,
    input  rs1_D, rs2_D, rd_D,
    output hazard_D, stall_MW,
    output rf_we, rf_waddr, rf_wdata
  );

  modport master (
    output wb_en_MW, rd_MW, wbdata_MW,
    output lt_issue, lt_issue_rd,
    output lt_valid, lt_rd, lt_data,
    input  lt_ready,
    output rs1_D, rs2_D, rd_D,
    input  hazard_D, stall_MW,
    input  rf_we, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/wb_late_fifo.sv
// Small synchronous FIFO for late results: valid/ready push, pop on grant,
// head visible combinationally, occupancy count exported.
module wb_late_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = RADDR_W + BUS_WIDTH,
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_valid,
  output logic                   push_ready,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign push_ready = (count_q != FULL_CNT);
  assign do_push    = push_valid && push_ready;
  assign do_pop     = pop && (count_q != '0);
  assign head_data  = mem[rd_ptr];
  assign count      = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs buffered late results,
// with starvation-forced stalls and a pending-destination scoreboard for decode.
module wb_port_arbiter #(
  parameter int unsigned BUS_WIDTH  = wb_port_arbiter_pkg::BUS_WIDTH,
  parameter int unsigned RADDR_W    = wb_port_arbiter_pkg::RADDR_W,
  parameter int unsigned FIFO_DEPTH = wb_port_arbiter_pkg::FIFO_DEPTH,
  parameter int unsigned MAX_WAIT   = wb_port_arbiter_pkg::MAX_WAIT
) (
  input logic               clk,
  input logic               rst_n,
  wb_port_arbiter_if.slave  bus
);

  import wb_port_arbiter_pkg::*;

  localparam int unsigned NREG  = 1 << RADDR_W;
  localparam int unsigned ENT_W = RADDR_W + BUS_WIDTH;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned AGE_W = $clog2(MAX_WAIT + 1);
  localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(MAX_WAIT - 1);

  arb_state_t           state_q, state_d;
  logic [AGE_W-1:0]     age_q, age_d;
  logic [NREG-1:0]      pending_q, pending_d;

  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_ready;
  logic                 fifo_push;
  logic                 push_acc;
  logic [ENT_W-1:0]     head_ent;
  logic [RADDR_W-1:0]   head_rd;
  logic [BUS_WIDTH-1:0] head_data;
  logic                 last_pop;

  logic                 pipe_req;
  logic                 pipe_we;
  logic                 late_we;
  logic                 stall;

  // x0 late results are acknowledged but never enter the buffer.
  assign fifo_push = bus.lt_valid && (bus.lt_rd != '0);
  assign push_acc  = fifo_push && fifo_ready;
  assign pipe_req  = bus.wb_en_MW && (bus.rd_MW != '0);
  assign last_pop  = (fifo_count == CNT_W'(1)) && !push_acc;
  assign {head_rd, head_data} = head_ent;

  wb_late_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (fifo_push),
    .push_ready (fifo_ready),
    .push_data  ({bus.lt_rd, bus.lt_data}),
    .pop        (late_we),
    .head_data  (head_ent),
    .count      (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    age_d   = age_q;
    pipe_we = 1'b0;
    late_we = 1'b0;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        pipe_we = pipe_req;
        if (push_acc) state_d = DRAIN;
      end
      DRAIN: begin
        if (pipe_req) begin
          pipe_we = 1'b1;
          if (age_q == AGE_LIMIT) begin
            state_d = FORCE;
            age_d   = '0;
          end else begin
            age_d = age_q + 1'b1;
          end
        end else begin
          late_we = 1'b1;
          age_d   = '0;
          if (last_pop) state_d = IDLE;
        end
      end
      FORCE: begin
        stall   = 1'b1;
        late_we = 1'b1;
        age_d   = '0;
        state_d = last_pop ? IDLE : DRAIN;
      end
      default: begin
        state_d = IDLE;
        age_d   = '0;
      end
    endcase
  end

  // A fresh issue to the same register outranks the clear from its late write.
  always_comb begin
    pending_d = pending_q;
    if (late_we) pending_d[head_rd] = 1'b0;
    if (bus.lt_issue && (bus.lt_issue_rd != '0)) pending_d[bus.lt_issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      age_q     <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      age_q     <= age_d;
      pending_q <= pending_d;
    end
  end

  assign bus.rf_we    = rst_n && (pipe_we || late_we);
  assign bus.rf_waddr = !rst_n ? '0 : late_we ? head_rd   : pipe_we ? bus.rd_MW     : '0;
  assign bus.rf_wdata = !rst_n ? '0 : late_we ? head_data : pipe_we ? bus.wbdata_MW : '0;
  assign bus.stall_MW = rst_n && stall;
  assign bus.lt_ready = rst_n && fifo_ready;
  assign bus.hazard_D = rst_n && (((bus.rs1_D != '0) && pending_q[bus.rs1_D]) ||
                                  ((bus.rs2_D != '0) && pending_q[bus.rs2_D]) ||
                                  ((bus.rd_D  != '0) && pending_q[bus.rd_D]));

  a_lt_valid_pending: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.lt_valid && (bus.lt_rd != '0)) |-> pending_q[bus.lt_rd]);

  a_wb_not_pending: assert property (@(posedge clk) disable iff (!rst_n)
    pipe_req |-> !pending_q[bus.rd_MW]);

endmodule
